// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word width, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetch and data requests onto a single-ported RAM,
// with data-first priority, alternation under contention, timeout and abort.
//
// state  | meaning
// IDLE   | no transaction; picks the next requester and latches its address/data/op
// IGRANT | instruction read owns the RAM until ACCESS, ERROR, timeout or withdrawal
// DGRANT | data read/write owns the RAM until ACCESS, ERROR, timeout or withdrawal
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT  = 64,
  parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  ramstate_t  ramstate,
  output logic       err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  word_t            addr_q, addr_d;
  word_t            wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_was_d_q, last_was_d_d;
  logic             err_q, err_d;

  logic  d_req;
  logic  done_ok;
  logic  done_err;
  logic  done;
  word_t rdata;

  assign d_req    = dREN | dWEN;
  assign done_ok  = (ramstate == ACCESS);
  assign done_err = (ramstate == ERROR) || (!done_ok && cnt_q == CNT_W'(TIMEOUT - 1));
  assign done     = done_ok | done_err;
  assign rdata    = done_ok ? ramload : ERR_WORD;
  assign err      = err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    last_was_d_d = last_was_d_q;
    err_d        = err_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;

    unique case (state_q)
      IDLE: begin
        // Under contention the data side wins unless it won last time.
        if (d_req && (!iREN || !last_was_d_q)) begin
          state_d = DGRANT;
          addr_d  = daddr;
          wdata_d = dstore;
          we_d    = dWEN;
          cnt_d   = '0;
        end else if (iREN) begin
          state_d = IGRANT;
          addr_d  = iaddr;
          wdata_d = '0;
          we_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (done) begin
          iwait        = 1'b0;
          iload        = rdata;
          state_d      = IDLE;
          last_was_d_d = 1'b0;
          if (done_err) err_d = 1'b1;
        end else if (!iREN) begin
          state_d = IDLE;
        end
      end

      DGRANT: begin
        ramREN   = !we_q;
        ramWEN   = we_q;
        ramaddr  = addr_q;
        ramstore = wdata_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if (done) begin
          dwait        = 1'b0;
          dload        = rdata;
          state_d      = IDLE;
          last_was_d_d = 1'b1;
          if (done_err) err_d = 1'b1;
        end else if (!d_req) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      last_was_d_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      last_was_d_q <= last_was_d_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: RAM model with programmable latency,
// expected completions queued at stimulus time and compared when a wait drops.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      i_ren = 1'b0;
  word_t     i_addr = '0;
  logic      i_wait;
  word_t     i_load;
  logic      d_ren = 1'b0;
  logic      d_wen = 1'b0;
  word_t     d_addr = '0;
  word_t     d_store = '0;
  logic      d_wait;
  word_t     d_load;
  logic      ram_ren;
  logic      ram_wen;
  word_t     ram_addr;
  word_t     ram_store;
  word_t     ram_load = '0;
  ramstate_t ram_state = FREE;
  logic      err;

  memory_arbiter dut (
    .CLK(clk), .RST(rst),
    .iREN(i_ren), .iaddr(i_addr), .iwait(i_wait), .iload(i_load),
    .dREN(d_ren), .dWEN(d_wen), .daddr(d_addr), .dstore(d_store),
    .dwait(d_wait), .dload(d_load),
    .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ram_addr), .ramstore(ram_store),
    .ramload(ram_load), .ramstate(ram_state), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_d; word_t data; } exp_t;
  typedef struct packed { logic is_d; logic [31:0] cyc; } done_t;

  exp_t  exp_q[$];
  done_t done_log[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc_n = 0;
  int    ram_lat = 1;
  bit    ram_err = 1'b0;
  int    busy_n = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic word_t ram_val(input word_t a);
    return a ^ 32'h8C010104;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // RAM model: ACCESS (or ERROR) on the ram_lat-th consecutive strobe cycle.
  always @(posedge clk) begin
    #1;
    if (ram_ren || ram_wen) begin
      busy_n++;
      if (busy_n == ram_lat) begin
        ram_state = ram_err ? ERROR : ACCESS;
        ram_load  = ram_err ? 32'h0 : ram_val(ram_addr);
      end else begin
        ram_state = BUSY;
        ram_load  = '0;
      end
    end else begin
      busy_n    = 0;
      ram_state = FREE;
      ram_load  = '0;
    end
  end

  // Scoreboard: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (!i_wait || !d_wait)) begin
      exp_t e;
      chk("single_done", {31'd0, i_wait ^ d_wait}, 32'd1);
      chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("done_kind", {31'd0, !d_wait}, {31'd0, e.is_d});
        chk("done_load", d_wait ? i_load : d_load, e.data);
      end
      done_log.push_back('{is_d: !d_wait, cyc: cyc_n});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int base;

    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_ramREN", {31'd0, ram_ren}, 32'd0);
    chk("rst_ramWEN", {31'd0, ram_wen}, 32'd0);
    chk("rst_ramaddr", ram_addr, 32'd0);
    chk("rst_ramstore", ram_store, 32'd0);
    chk("rst_waits", {30'd0, i_wait, d_wait}, 32'd3);
    chk("rst_loads", i_load | d_load, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Single instruction read, RAM answers on the second strobe cycle.
    cyc();
    g = cyc_n; ram_lat = 2;
    i_ren = 1'b1; i_addr = 32'h100;
    exp_q.push_back('{is_d: 1'b0, data: 32'h8C010004});
    base = done_log.size();
    cyc();
    chk("t1_ramREN", {31'd0, ram_ren}, 32'd1);
    chk("t1_ramaddr", ram_addr, 32'h100);
    chk("t1_iwait_busy", {31'd0, i_wait}, 32'd1);
    cyc();
    chk("t1_iwait_done", {31'd0, i_wait}, 32'd0);
    chk("t1_iload", i_load, 32'h8C010004);
    chk("t1_dwait", {31'd0, d_wait}, 32'd1);
    i_ren = 1'b0;
    cyc();
    chk("t1_iwait_after", {31'd0, i_wait}, 32'd1);
    chk("t1_ramREN_idle", {31'd0, ram_ren}, 32'd0);
    cyc();
    chk("t1_one_done", done_log.size() - base, 32'd1);
    if (done_log.size() > base) chk("t1_latency", done_log[base].cyc - g, 32'd2);

    // Simultaneous instruction read and data write: data first, then instruction.
    cyc();
    g = cyc_n; ram_lat = 1;
    i_ren = 1'b1; i_addr = 32'h104;
    d_wen = 1'b1; d_addr = 32'h200; d_store = 32'hDEADBEEF;
    exp_q.push_back('{is_d: 1'b1, data: ram_val(32'h200)});
    exp_q.push_back('{is_d: 1'b0, data: ram_val(32'h104)});
    cyc();
    chk("t2_ramWEN", {31'd0, ram_wen}, 32'd1);
    chk("t2_ramREN", {31'd0, ram_ren}, 32'd0);
    chk("t2_ramstore", ram_store, 32'hDEADBEEF);
    chk("t2_ramaddr", ram_addr, 32'h200);
    chk("t2_dwait", {31'd0, d_wait}, 32'd0);
    chk("t2_iwait", {31'd0, i_wait}, 32'd1);
    d_wen = 1'b0;
    cyc();
    chk("t2_idle_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
    cyc();
    chk("t2_igrant_ren", {31'd0, ram_ren}, 32'd1);
    chk("t2_igrant_addr", ram_addr, 32'h104);
    chk("t2_iwait", {31'd0, i_wait}, 32'd0);
    i_ren = 1'b0;
    cyc();

    // Fairness: both requests held, grants alternate D, I, D, I.
    cyc();
    ram_lat = 2;
    d_ren = 1'b1; d_addr = 32'h280;
    i_ren = 1'b1; i_addr = 32'h180;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{is_d: 1'b1, data: ram_val(32'h280)});
      exp_q.push_back('{is_d: 1'b0, data: ram_val(32'h180)});
    end
    base = done_log.size();
    for (int k = 0; k < 40 && done_log.size() < base + 4; k++) cyc();
    d_ren = 1'b0; i_ren = 1'b0;
    chk("fair_count", done_log.size() - base, 32'd4);
    for (int k = 1; k < 4; k++)
      if (done_log.size() > base + k)
        chk("fair_gap", done_log[base + k].cyc - done_log[base + k - 1].cyc, 32'd3);
    repeat (3) cyc();
    chk("fair_no_extra", done_log.size() - base, 32'd4);
    chk("sb_drained", exp_q.size(), 32'd0);

    // Abort: data read withdrawn after one BUSY cycle.
    ram_lat = 1000;
    base = done_log.size();
    d_ren = 1'b1; d_addr = 32'h400;
    cyc();
    chk("ab_ramREN", {31'd0, ram_ren}, 32'd1);
    d_ren = 1'b0;
    cyc();
    chk("ab_ramREN_idle", {31'd0, ram_ren}, 32'd0);
    chk("ab_err", {31'd0, err}, 32'd0);
    chk("ab_dwait", {31'd0, d_wait}, 32'd1);

    // Reset in the middle of a data grant.
    d_ren = 1'b1; d_addr = 32'h404;
    cyc();
    chk("rm_ramaddr", ram_addr, 32'h404);
    rst = 1'b1;
    cyc();
    rst = 1'b0; d_ren = 1'b0;
    chk("rm_ramREN", {31'd0, ram_ren}, 32'd0);
    chk("rm_ramaddr0", ram_addr, 32'd0);
    chk("rm_waits", {30'd0, i_wait, d_wait}, 32'd3);
    chk("rm_no_done", done_log.size() - base, 32'd0);

    // RAM ERROR on an instruction read.
    cyc();
    ram_lat = 1; ram_err = 1'b1;
    i_ren = 1'b1; i_addr = 32'h500;
    exp_q.push_back('{is_d: 1'b0, data: 32'hBAD1BAD1});
    cyc();
    chk("er_iwait", {31'd0, i_wait}, 32'd0);
    chk("er_iload", i_load, 32'hBAD1BAD1);
    i_ren = 1'b0;
    cyc();
    ram_err = 1'b0;
    chk("er_err_set", {31'd0, err}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("er_err_cleared", {31'd0, err}, 32'd0);

    // Timeout: RAM stays BUSY, completion forced TIMEOUT cycles after the grant.
    cyc();
    g = cyc_n; ram_lat = 1000;
    d_ren = 1'b1; d_addr = 32'h600;
    exp_q.push_back('{is_d: 1'b1, data: 32'hBAD1BAD1});
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (!d_wait) break;
    end
    chk("to_latency", cyc_n - g, 32'd64);
    chk("to_dload", d_load, 32'hBAD1BAD1);
    chk("to_err_not_yet", {31'd0, err}, 32'd0);
    d_ren = 1'b0;
    cyc();
    chk("to_err_set", {31'd0, err}, 32'd1);
    repeat (5) cyc();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("to_err_rst", {31'd0, err}, 32'd0);
    chk("sb_final", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Sits directly downstream of the request unit and the instruction fetch path. It arbitrates the instruction-fetch request (iREN) and the data request (dREN/dWEN) onto the single-ported RAM, and returns iwait/dwait, from which the datapath derives ihit/dhit. It is a registered FSM with data-first priority plus a fairness flag, a per-transaction timeout counter, and abort on request withdrawal.

Parameters:
TIMEOUT, 64, maximum cycles a granted transaction may wait for ramstate==ACCESS before it is force-completed with an error.
ERR_WORD, 32'hBAD1BAD1, value returned on iload/dload when a transaction completes by error or timeout.

Ports:
CLK  in  1  system clock; all state updates on posedge.
RST  in  1  synchronous reset, active-high.
iREN  in  1  instruction read request.
iaddr  in  32  instruction word address.
iwait  out  1  0 only in the cycle iload is valid.
iload  out  32  instruction read data.
dREN  in  1  data read request (from request unit).
dWEN  in  1  data write request (from request unit); dREN and dWEN are never both 1.
daddr  in  32  data address.
dstore  in  32  data write value.
dwait  out  1  0 only in the cycle the data access completes.
dload  out  32  data read value.
ramREN  out  1  RAM read strobe.
ramWEN  out  1  RAM write strobe.
ramaddr  out  32  RAM address.
ramstore  out  32  RAM write data.
ramload  in  32  RAM read data.
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
err  out  1  sticky; set on any ERROR or timeout; cleared only by RST.

Behaviour:
- States: IDLE, IGRANT, DGRANT. Registers: state, latched addr/wdata/op, cnt (clog2(TIMEOUT+1) bits), last_was_d, err.
- Reset (RST=1 at posedge): state=IDLE, cnt=0, last_was_d=0, err=0. Reset dominates any in-flight transaction; the RAM strobes drop on the next cycle. Outputs in IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=dload=0.
- IDLE: if a data request and an instruction request are both pending, DGRANT is chosen unless last_was_d=1, in which case IGRANT is chosen. A single pending request is granted directly. The grant cycle latches addr/dstore/op. No RAM strobe is driven in IDLE.
- Grant states drive ramREN/ramWEN/ramaddr/ramstore from the latched values; they do not follow the live inputs.
- Completion occurs when ramstate==ACCESS. In that cycle, the matching wait output is 0 (combinational from state and ramstate), and iload/dload=ramload. Next state is IDLE; last_was_d is updated (1 after DGRANT, 0 after IGRANT). Minimum latency from request to completion is 2 cycles: 1 grant cycle plus at least 1 RAM cycle.
- The non-granted wait output stays 1 throughout.
- Error: ramstate==ERROR, or cnt==TIMEOUT-1 while not ACCESS, completes the transaction the same way, except load=ERR_WORD; err is set.
- cnt resets to 0 on each grant and increments each cycle in a grant state.
- Abort: if the granted request is deasserted (iREN=0 in IGRANT, or dREN=dWEN=0 in DGRANT) before ACCESS, the next state is IDLE. There is no completion and err is not set. This does not apply in the completion cycle itself.
- Back-to-back: completion is followed by 1 IDLE cycle before the next grant.

Decomposition:
- cpu_types_pkg: word_t (32b) and ramstate_t enum {FREE, BUSY, ACCESS, ERROR}. Add arb_state_t {IDLE, IGRANT, DGRANT} there.
- Sub-module: none required. The timeout counter is inline.

Test Plan:
- Reset, then iREN=1, iaddr=0x100; RAM gives ACCESS 2 cycles after grant with ramload=0x8C010004 -> ramREN=1, ramaddr=0x100 from the grant cycle; iwait=0 for exactly 1 cycle; iload=0x8C010004; dwait=1 throughout.
- iREN=1 and dWEN=1 simultaneously (daddr=0x200, dstore=0xDEADBEEF) -> DGRANT first with ramWEN=1, ramstore=0xDEADBEEF; after dwait pulses low, 1 IDLE cycle, then IGRANT.
- Fairness: dREN and iREN held continuously -> grants alternate D, I, D, I with 1 IDLE cycle between each.
- Timeout: dREN=1 and ramstate held BUSY -> dwait=0 on cycle TIMEOUT after the grant (64); dload=0xBAD1BAD1; err=1 and stays 1 until RST.
- Abort and reset: dREN dropped after 1 BUSY cycle -> IDLE next cycle, ramREN=0, err=0. RST asserted mid-DGRANT -> all outputs return to reset values at the next posedge.
